// File: rtl/z80_mem16_seq_if.sv
// Word-request and byte-bus signal bundle for the 16-bit memory operand sequencer.
// slave = sequencer view, master = decoder/memory side view.
interface z80_mem16_seq_if;
  localparam int unsigned AW = 16;
  localparam int unsigned WW = 16;
  localparam int unsigned BW = 8;

  logic          start;
  logic          start_ready;
  logic          op_write;
  logic [AW-1:0] op_addr;
  logic [WW-1:0] op_wdata;
  logic          done;
  logic          err;
  logic [WW-1:0] rdata;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [BW-1:0] bus_wdata;
  logic [BW-1:0] bus_rdata;
  logic          bus_ack;

  modport slave (
    input  start, op_write, op_addr, op_wdata, bus_rdata, bus_ack,
    output start_ready, done, err, rdata, bus_req, bus_we, bus_addr, bus_wdata
  );

  modport master (
    output start, op_write, op_addr, op_wdata, bus_rdata, bus_ack,
    input  start_ready, done, err, rdata, bus_req, bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/z80_mem16_seq.sv
// Splits one 16-bit memory operand transfer into two byte bus cycles (nn, nn+1), little-endian.
// Optional trace outputs enabled by defining Z80_MEM16_SEQ_TRACE_EN.
module z80_mem16_seq #(
  parameter int unsigned MAX_WAIT = 0
) (
  input  logic            clk,
  input  logic            reset,
  z80_mem16_seq_if.slave  bus
`ifdef Z80_MEM16_SEQ_TRACE_EN
  ,
  output logic            trc_valid,
  output logic            trc_write,
  output logic [15:0]     trc_addr1,
  output logic [15:0]     trc_addr2,
  output logic [7:0]      trc_data1,
  output logic [7:0]      trc_data2
`endif
);

  localparam int unsigned AW = 16;
  localparam int unsigned WW = 16;
  localparam int unsigned BW = 8;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] WAIT_LIM = CW'(MAX_WAIT);
  localparam bit            TO_EN    = (MAX_WAIT != 0);

  typedef enum logic [1:0] {IDLE, LO, HI, FIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [WW-1:0] wdata_q, wdata_d;
  logic          write_q, write_d;
  logic [BW-1:0] lo_q, lo_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [WW-1:0] rdata_q, rdata_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [AW-1:0] baddr_q, baddr_d;
  logic [BW-1:0] bwd_q, bwd_d;

  logic ack_c;
  logic timeout_c;

  assign ack_c     = bus.bus_ack & req_q;
  assign timeout_c = TO_EN && (wcnt_q == WAIT_LIM - CW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      lo_q    <= '0;
      wcnt_q  <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      baddr_q <= '0;
      bwd_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      lo_q    <= lo_d;
      wcnt_q  <= wcnt_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      baddr_q <= baddr_d;
      bwd_q   <= bwd_d;
    end
  end

  // Next state and next registered outputs; an ack on the timeout edge takes priority.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    lo_d    = lo_q;
    wcnt_d  = wcnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    req_d   = req_q;
    we_d    = we_q;
    baddr_d = baddr_q;
    bwd_d   = bwd_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          addr_d  = bus.op_addr;
          wdata_d = bus.op_wdata;
          write_d = bus.op_write;
          wcnt_d  = '0;
          req_d   = 1'b1;
          we_d    = bus.op_write;
          baddr_d = bus.op_addr;
          bwd_d   = bus.op_wdata[7:0];
          state_d = LO;
        end
      end
      LO: begin
        if (ack_c) begin
          if (!write_q) lo_d = bus.bus_rdata;
          wcnt_d  = '0;
          baddr_d = addr_q + AW'(1);
          bwd_d   = wdata_q[15:8];
          state_d = HI;
        end else if (timeout_c) begin
          req_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      HI: begin
        if (ack_c) begin
          if (!write_q) rdata_d = {bus.bus_rdata, lo_q};
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = FIN;
        end else if (timeout_c) begin
          req_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  assign bus.start_ready = ready_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.rdata       = rdata_q;
  assign bus.bus_req     = req_q;
  assign bus.bus_we      = we_q;
  assign bus.bus_addr    = baddr_q;
  assign bus.bus_wdata   = bwd_q;

`ifdef Z80_MEM16_SEQ_TRACE_EN
  // Trace record captured on the edge entering FIN; bytes never transferred read as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trc_valid <= 1'b0;
      trc_write <= 1'b0;
      trc_addr1 <= '0;
      trc_addr2 <= '0;
      trc_data1 <= '0;
      trc_data2 <= '0;
    end else begin
      trc_valid <= done_d;
      if (done_d) begin
        trc_write <= write_q;
        trc_addr1 <= addr_q;
        trc_addr2 <= addr_q + AW'(1);
        trc_data1 <= (state_q == LO) ? 8'h00 : (write_q ? wdata_q[7:0] : lo_q);
        trc_data2 <= err_d ? 8'h00 : (write_q ? wdata_q[15:8] : bus.bus_rdata);
      end
    end
  end
`endif

endmodule

// File: tb/tb_z80_mem16_seq.sv
// Directed bench for z80_mem16_seq: main instance MAX_WAIT=4, second instance MAX_WAIT=0.
// Trace checks are compiled when Z80_MEM16_SEQ_TRACE_EN is defined.
module tb_z80_mem16_seq;

  logic clk;
  logic reset;
  int   vecs;
  int   miscompares;

  logic [7:0] mem [0:65535];

  // Results of the last run_op call
  int          r_done_cyc;
  int          r_hi_cyc;
  logic [15:0] r_addr_lo;
  logic [15:0] r_addr_hi;
  logic        r_we_lo;
  logic        r_we_hi;
  bit          r_stable;

  z80_mem16_seq_if bus ();
  z80_mem16_seq_if bus0 ();

`ifdef Z80_MEM16_SEQ_TRACE_EN
  logic        trc_valid, trc_write, trc0_valid, trc0_write;
  logic [15:0] trc_addr1, trc_addr2, trc0_addr1, trc0_addr2;
  logic [7:0]  trc_data1, trc_data2, trc0_data1, trc0_data2;
`endif

  z80_mem16_seq #(.MAX_WAIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef Z80_MEM16_SEQ_TRACE_EN
    ,
    .trc_valid (trc_valid),
    .trc_write (trc_write),
    .trc_addr1 (trc_addr1),
    .trc_addr2 (trc_addr2),
    .trc_data1 (trc_data1),
    .trc_data2 (trc_data2)
`endif
  );

  z80_mem16_seq #(.MAX_WAIT(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
`ifdef Z80_MEM16_SEQ_TRACE_EN
    ,
    .trc_valid (trc0_valid),
    .trc_write (trc0_write),
    .trc_addr1 (trc0_addr1),
    .trc_addr2 (trc0_addr2),
    .trc_data1 (trc0_data1),
    .trc_data2 (trc0_data2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one word op on the main instance and act as memory; wlo/whi = wait cycles per beat,
  // poke = cycle after accept at which a stray start is pulsed (0 = none).
  task automatic run_op(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                        input int wlo, input int whi, input int poke);
    int beat;
    int waited;
    logic [15:0] s_addr;
    logic [7:0]  s_wd;
    logic        s_we;
    @(negedge clk);
    bus.start = 1'b1; bus.op_write = wr; bus.op_addr = a; bus.op_wdata = wd;
    @(negedge clk);
    bus.start = 1'b0; bus.op_addr = ~a; bus.op_wdata = ~wd; bus.op_write = ~wr;
    beat = 0; waited = 0; r_done_cyc = -1; r_hi_cyc = 0; r_stable = 1'b1;
    s_addr = '0; s_wd = '0; s_we = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      bus.bus_ack = 1'b0;
      bus.start   = 1'b0;
      if (c == poke) begin
        bus.start = 1'b1; bus.op_addr = a ^ 16'h0F0F; bus.op_write = ~wr;
      end
      if (bus.done) begin
        r_done_cyc = c;
        break;
      end
      if (bus.bus_req) begin
        if (waited == 0) begin
          s_addr = bus.bus_addr; s_wd = bus.bus_wdata; s_we = bus.bus_we;
        end else if (bus.bus_addr !== s_addr || bus.bus_wdata !== s_wd || bus.bus_we !== s_we) begin
          r_stable = 1'b0;
        end
        if (beat == 1) r_hi_cyc++;
        if (waited >= ((beat == 0) ? wlo : whi)) begin
          bus.bus_ack   = 1'b1;
          bus.bus_rdata = mem[bus.bus_addr];
          if (bus.bus_we) mem[bus.bus_addr] = bus.bus_wdata;
          if (beat == 0) begin r_addr_lo = bus.bus_addr; r_we_lo = bus.bus_we; end
          else           begin r_addr_hi = bus.bus_addr; r_we_hi = bus.bus_we; end
          beat++;
          waited = 0;
        end else begin
          bus.bus_rdata = 8'($urandom);
          waited++;
        end
      end
      @(negedge clk);
    end
    bus.start   = 1'b0;
    bus.bus_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    vecs++; if (bus.start_ready !== 1'b1) begin miscompares++; $display("FAIL reset_start_ready got %b want 1", bus.start_ready); end
    vecs++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", bus.done); end
    vecs++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", bus.err); end
    vecs++; if (bus.rdata !== 16'h0000) begin miscompares++; $display("FAIL reset_rdata got %h want 0000", bus.rdata); end
    vecs++; if (bus.bus_req !== 1'b0 || bus.bus_we !== 1'b0) begin miscompares++; $display("FAIL reset_req_we got %b%b want 00", bus.bus_req, bus.bus_we); end
    vecs++; if (bus.bus_addr !== 16'h0000 || bus.bus_wdata !== 8'h00) begin miscompares++; $display("FAIL reset_bus got %h/%h want 0000/00", bus.bus_addr, bus.bus_wdata); end
`ifdef Z80_MEM16_SEQ_TRACE_EN
    vecs++; if (trc_valid !== 1'b0 || trc_addr1 !== 16'h0) begin miscompares++; $display("FAIL reset_trace got %b/%h want 0/0000", trc_valid, trc_addr1); end
`endif
    bus.bus_ack = 1'b1;
    repeat (2) @(negedge clk);
    vecs++; if (bus.done !== 1'b0 || bus.bus_req !== 1'b0 || bus.start_ready !== 1'b1) begin
      miscompares++; $display("FAIL idle_ack done/req/ready got %b%b%b want 001", bus.done, bus.bus_req, bus.start_ready);
    end
    bus.bus_ack = 1'b0;
  endtask

  task automatic test_load_zero_wait();
    mem[16'h1234] = 8'hCD; mem[16'h1235] = 8'hAB;
    run_op(1'b0, 16'h1234, 16'h0000, 0, 0, 0);
    vecs++; if (r_addr_lo !== 16'h1234 || r_addr_hi !== 16'h1235) begin miscompares++; $display("FAIL load_addrs got %h,%h want 1234,1235", r_addr_lo, r_addr_hi); end
    vecs++; if (r_done_cyc != 3) begin miscompares++; $display("FAIL load_latency got %0d want 3", r_done_cyc); end
    vecs++; if (bus.rdata !== 16'hABCD || bus.err !== 1'b0) begin miscompares++; $display("FAIL load_rdata got %h err %b want ABCD err 0", bus.rdata, bus.err); end
    vecs++; if (r_we_lo !== 1'b0 || r_we_hi !== 1'b0) begin miscompares++; $display("FAIL load_we got %b%b want 00", r_we_lo, r_we_hi); end
`ifdef Z80_MEM16_SEQ_TRACE_EN
    vecs++; if (trc_valid !== 1'b1 || trc_write !== 1'b0) begin miscompares++; $display("FAIL trace_valid got %b/%b want 1/0", trc_valid, trc_write); end
    vecs++; if (trc_addr1 !== 16'h1234 || trc_addr2 !== 16'h1235) begin miscompares++; $display("FAIL trace_addr got %h,%h want 1234,1235", trc_addr1, trc_addr2); end
    vecs++; if (trc_data1 !== 8'hCD || trc_data2 !== 8'hAB) begin miscompares++; $display("FAIL trace_data got %h,%h want CD,AB", trc_data1, trc_data2); end
`endif
    @(negedge clk);
    vecs++; if (bus.done !== 1'b0 || bus.start_ready !== 1'b1) begin miscompares++; $display("FAIL done_pulse done/ready got %b%b want 01", bus.done, bus.start_ready); end
  endtask

  task automatic test_store_waits();
    run_op(1'b1, 16'h4000, 16'hBEEF, 2, 2, 0);
    vecs++; if (mem[16'h4000] !== 8'hEF || mem[16'h4001] !== 8'hBE) begin miscompares++; $display("FAIL store_mem got %h,%h want EF,BE", mem[16'h4000], mem[16'h4001]); end
    vecs++; if (r_done_cyc != 7) begin miscompares++; $display("FAIL store_latency got %0d want 7", r_done_cyc); end
    vecs++; if (r_stable !== 1'b1) begin miscompares++; $display("FAIL store_stable got %b want 1", r_stable); end
    vecs++; if (r_we_lo !== 1'b1 || r_we_hi !== 1'b1) begin miscompares++; $display("FAIL store_we got %b%b want 11", r_we_lo, r_we_hi); end
    vecs++; if (bus.rdata !== 16'hABCD || bus.err !== 1'b0) begin miscompares++; $display("FAIL store_rdata got %h err %b want ABCD err 0", bus.rdata, bus.err); end
  endtask

  task automatic test_wrap();
    mem[16'hFFFF] = 8'h11; mem[16'h0000] = 8'h22;
    run_op(1'b0, 16'hFFFF, 16'h0000, 0, 0, 0);
    vecs++; if (r_addr_hi !== 16'h0000) begin miscompares++; $display("FAIL wrap_addr got %h want 0000", r_addr_hi); end
    vecs++; if (bus.rdata !== 16'h2211) begin miscompares++; $display("FAIL wrap_rdata got %h want 2211", bus.rdata); end
  endtask

  task automatic test_ack_at_limit();
    mem[16'h2000] = 8'h5A; mem[16'h2001] = 8'hA5;
    run_op(1'b0, 16'h2000, 16'h0000, 0, 3, 0);
    vecs++; if (r_done_cyc != 6 || bus.err !== 1'b0) begin miscompares++; $display("FAIL limit_ack cyc %0d err %b want 6 err 0", r_done_cyc, bus.err); end
    vecs++; if (bus.rdata !== 16'hA55A || r_hi_cyc != 4) begin miscompares++; $display("FAIL limit_rdata got %h hi %0d want A55A hi 4", bus.rdata, r_hi_cyc); end
  endtask

  task automatic test_timeout();
    mem[16'h3000] = 8'h77; mem[16'h3001] = 8'h88;
    run_op(1'b0, 16'h3000, 16'h0000, 0, 1000, 0);
    vecs++; if (r_done_cyc != 6 || r_hi_cyc != 4) begin miscompares++; $display("FAIL timeout_cyc got %0d hi %0d want 6 hi 4", r_done_cyc, r_hi_cyc); end
    vecs++; if (bus.err !== 1'b1 || bus.bus_req !== 1'b0) begin miscompares++; $display("FAIL timeout_err err/req got %b%b want 10", bus.err, bus.bus_req); end
    vecs++; if (bus.rdata !== 16'hA55A) begin miscompares++; $display("FAIL timeout_rdata got %h want A55A", bus.rdata); end
`ifdef Z80_MEM16_SEQ_TRACE_EN
    vecs++; if (trc_valid !== 1'b1 || trc_addr2 !== 16'h3001) begin miscompares++; $display("FAIL trace_to_valid got %b/%h want 1/3001", trc_valid, trc_addr2); end
    vecs++; if (trc_data1 !== 8'h77 || trc_data2 !== 8'h00) begin miscompares++; $display("FAIL trace_to_data got %h,%h want 77,00", trc_data1, trc_data2); end
`endif
  endtask

  task automatic test_busy();
    bit extra;
    mem[16'h5000] = 8'h01; mem[16'h5001] = 8'h02;
    run_op(1'b0, 16'h5000, 16'h0000, 1, 0, 1);
    vecs++; if (r_done_cyc != 4 || r_addr_lo !== 16'h5000 || r_addr_hi !== 16'h5001) begin
      miscompares++; $display("FAIL busy_op cyc %0d addrs %h,%h want 4 5000,5001", r_done_cyc, r_addr_lo, r_addr_hi);
    end
    vecs++; if (bus.rdata !== 16'h0201) begin miscompares++; $display("FAIL busy_rdata got %h want 0201", bus.rdata); end
    extra = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.bus_req !== 1'b0 || bus.done !== 1'b0) extra = 1'b1;
    end
    vecs++; if (extra !== 1'b0) begin miscompares++; $display("FAIL busy_ignored extra op seen %b want 0", extra); end
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    @(negedge clk);
    bus.start = 1'b1; bus.op_write = 1'b0; bus.op_addr = 16'h1234;
    @(negedge clk);
    bus.start = 1'b0;
    bus.bus_ack = 1'b1; bus.bus_rdata = mem[16'h1234];
    @(negedge clk);
    bus.bus_ack = 1'b0;
    vecs++; if (bus.bus_req !== 1'b1 || bus.bus_addr !== 16'h1235) begin miscompares++; $display("FAIL mid_hi req/addr got %b/%h want 1/1235", bus.bus_req, bus.bus_addr); end
    reset = 1'b1;
    #1;
    vecs++; if (bus.bus_req !== 1'b0 || bus.done !== 1'b0) begin miscompares++; $display("FAIL mid_reset req/done got %b%b want 00", bus.bus_req, bus.done); end
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.bus_req !== 1'b0) saw_done = 1'b1;
    end
    vecs++; if (saw_done !== 1'b0 || bus.start_ready !== 1'b1) begin miscompares++; $display("FAIL mid_after got done %b ready %b want 0 1", saw_done, bus.start_ready); end
    run_op(1'b0, 16'h1234, 16'h0000, 0, 0, 0);
    vecs++; if (r_done_cyc != 3 || bus.rdata !== 16'hABCD || bus.err !== 1'b0) begin
      miscompares++; $display("FAIL mid_reload cyc %0d rdata %h err %b want 3 ABCD 0", r_done_cyc, bus.rdata, bus.err);
    end
  endtask

  // MAX_WAIT=0 instance never times out: a 10-cycle wait on the low beat still completes.
  task automatic test_no_timeout();
    int done_cyc;
    @(negedge clk);
    bus0.start = 1'b1; bus0.op_write = 1'b0; bus0.op_addr = 16'h1234;
    @(negedge clk);
    bus0.start = 1'b0; bus0.op_addr = 16'h0000;
    done_cyc = -1;
    for (int c = 1; c <= 60; c++) begin
      bus0.bus_ack = 1'b0;
      if (bus0.done) begin
        done_cyc = c;
        break;
      end
      if (bus0.bus_req && c >= 11) begin
        bus0.bus_ack = 1'b1; bus0.bus_rdata = mem[bus0.bus_addr];
      end
      @(negedge clk);
    end
    bus0.bus_ack = 1'b0;
    vecs++; if (done_cyc != 13 || bus0.err !== 1'b0) begin miscompares++; $display("FAIL nowait_done cyc %0d err %b want 13 0", done_cyc, bus0.err); end
    vecs++; if (bus0.rdata !== 16'hABCD) begin miscompares++; $display("FAIL nowait_rdata got %h want ABCD", bus0.rdata); end
`ifdef Z80_MEM16_SEQ_TRACE_EN
    vecs++; if (trc0_valid !== 1'b1 || trc0_write !== 1'b0 || trc0_addr1 !== 16'h1234 || trc0_addr2 !== 16'h1235 || trc0_data1 !== 8'hCD || trc0_data2 !== 8'hAB) begin
      miscompares++; $display("FAIL nowait_trace got %b %h %h %h %h want 1 1234 1235 CD AB", trc0_valid, trc0_addr1, trc0_addr2, trc0_data1, trc0_data2);
    end
`endif
  endtask

  initial begin
    vecs = 0; miscompares = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.op_write = 1'b0; bus.op_addr = '0; bus.op_wdata = '0;
    bus.bus_ack = 1'b0; bus.bus_rdata = '0;
    bus0.start = 1'b0; bus0.op_write = 1'b0; bus0.op_addr = '0; bus0.op_wdata = '0;
    bus0.bus_ack = 1'b0; bus0.bus_rdata = '0;
    r_addr_lo = '0; r_addr_hi = '0; r_we_lo = 1'b0; r_we_hi = 1'b0;
    test_reset();
    test_load_zero_wait();
    test_store_waits();
    test_wrap();
    test_ack_at_limit();
    test_timeout();
    test_busy();
    test_reset_mid();
    test_no_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule

// File: doc/z80_mem16_seq.md
Name: z80_mem16_seq

Overview:
- Sequences every 16-bit memory operand transfer in the core: LD rr,(nn), LD (nn),rr, LD IX/IY,(nn), LD (nn),IX/IY and stack-pair accesses.
- Takes one word request from the instruction decoder and splits it into two byte bus cycles: low byte at addr, high byte at addr+1.
- Handles bus wait states and returns the little-endian assembled word with a done pulse.
- Sits between the decoder/register file and the shared byte-wide memory bus.

Parameters:
- MAX_WAIT, 0, max cycles a beat may wait for bus_ack; 0 = wait forever (no timeout). 8-bit wait counter, legal range 0..255.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; accepted only when start_ready=1.
- start_ready  out  1  high in IDLE only.
- op_write  in  1  1 = store word, 0 = load word; sampled on accept.
- op_addr  in  16  word address nn; sampled on accept.
- op_wdata  in  16  store data; [7:0] goes to nn, [15:8] to nn+1; sampled on accept.
- done  out  1  one-cycle pulse when the operation ends (success or timeout).
- err  out  1  valid with done; 1 = timeout abort.
- rdata  out  16  {byte@nn+1, byte@nn}; valid from done until the next accept.
- bus_req  out  1  byte cycle request.
- bus_we  out  1  byte cycle is a write.
- bus_addr  out  16  byte address.
- bus_wdata  out  8  byte write data.
- bus_rdata  in  8  byte read data; sampled on the ack edge.
- bus_ack  in  1  completes the beat at a rising edge where bus_req=1.

Behaviour:
- Reset values: start_ready=1, done=0, err=0, rdata=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, all internal registers 0, state IDLE.
- States: IDLE, LO, HI, FIN.
- IDLE:
  - start=1 latches op_* and enters LO.
  - bus_req rises the next cycle, so request to bus is 1 cycle.
- LO:
  - Drives bus_req=1, bus_we=op_write, bus_addr=addr, bus_wdata=wdata[7:0].
  - On ack: capture rdata_lo (loads only) and go to HI.
  - bus_req stays high across the transition; no idle cycle between beats.
- HI:
  - Drives bus_addr=addr+1 mod 2^16 (FFFF wraps to 0000) and bus_wdata=wdata[15:8].
  - On ack: capture rdata_hi and go to FIN.
- FIN:
  - bus_req=0, done=1 for exactly one cycle; rdata updated this cycle; next state IDLE.
  - Minimum latency with zero wait states: accept edge to done = 3 cycles.
- Outputs must not change while bus_req=1 and bus_ack=0.
- Any start while start_ready=0 is ignored; no queue.
- Stores leave rdata unchanged.
- Timeout:
  - Wait counter clears at each beat start and increments each cycle the beat is not acked.
  - When MAX_WAIT>0 and the counter reaches MAX_WAIT with no ack: drop bus_req, go to FIN with err=1; rdata unchanged.
  - An ack arriving on the same edge as the timeout wins: the beat completes normally.
- Async reset mid-operation: bus_req falls immediately (not clock-qualified), the operation is discarded, no done pulse, state IDLE.
- bus_ack while bus_req=0 is ignored.

Optional Feature:
- Macro: Z80_MEM16_SEQ_TRACE_EN.
- Enabled, adds trace outputs, registered and reset to 0:
  - trc_valid: one-cycle pulse coincident with done.
  - trc_write.
  - trc_addr1 = nn, trc_addr2 = nn+1.
  - trc_data1 / trc_data2: low/high bytes transferred.
  - These mirror the mem_raddr/raddr2 (or waddr/waddr2) and rdata/rdata2 fields the Z80FI formal checks compare against.
  - On timeout, trc_valid still pulses; data fields hold bytes actually transferred, 0 for a byte not transferred.
- Disabled: the trace ports do not exist and there is no trace logic; functional behaviour is identical.

Test Plan:
- Load, MAX_WAIT=0, zero waits: op_addr=1234, memory 1234=CD, 1235=AB → bus addrs 1234 then 1235; done 3 cycles after accept; rdata=ABCD; err=0.
- Store with waits: op_addr=4000, op_wdata=BEEF, ack delayed 2 cycles per beat → writes EF@4000, BE@4001; bus outputs stable while waiting; done at cycle 7.
- Wrap: load op_addr=FFFF, memory FFFF=11, 0000=22 → second beat addr 0000; rdata=2211.
- Timeout: MAX_WAIT=4, ack never asserted on HI beat → bus_req drops; done=1, err=1; rdata keeps its previous value.
- Busy/reset: start pulsed during LO → ignored (one op only). Async reset asserted during HI → bus_req=0 immediately, no done pulse; then a new load completes normally.
- Trace (macro on): load 1234 → trc_valid with done; trc_addr1=1234, trc_addr2=1235, trc_data1=CD, trc_data2=AB.
